// File: rtl/mem_master_pkg.sv
// Shared types and width helpers for the mem_master burst initiator.
package mem_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      WR_BEAT,
      VERIFY,
      DONE,
      ERR
   } state_t;

   // Width of the burst-length field; a single-word burst still needs one bit.
   function automatic int len_width(input int max_burst);
      return (max_burst > 1) ? $clog2(max_burst) : 1;
   endfunction

   // Width of a counter that runs 0 .. latency-1.
   function automatic int lat_width(input int latency);
      return (latency > 1) ? $clog2(latency) : 1;
   endfunction

endpackage

// File: rtl/mem_master_if.sv
// Single-port word memory bus; mem_master drives it through the master modport.
interface mem_master_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int WORD_WIDTH = 32
);
   logic                  memRead;
   logic                  memWrite;
   logic [ADDR_WIDTH-1:0] address;
   logic [WORD_WIDTH-1:0] data_out;
   logic [WORD_WIDTH-1:0] data_in;

   modport master (output memRead, memWrite, address, data_out, input data_in);
   modport slave  (input memRead, memWrite, address, data_out, output data_in);
endinterface

// File: rtl/mem_addr_gen.sv
// Burst address generator: base address, beat counter, last-beat and wrap detection.
module mem_addr_gen
   import mem_master_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int LEN_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  inc,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [LEN_W-1:0]      len,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  last,
   output logic                  range_err
);

   localparam logic [ADDR_WIDTH:0] ADDR_MAX = {1'b0, {ADDR_WIDTH{1'b1}}};

   logic [ADDR_WIDTH-1:0] base;
   logic [LEN_W-1:0]      len_q;
   logic [LEN_W-1:0]      beat;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         base  <= '0;
         len_q <= '0;
         beat  <= '0;
      end else if (load) begin
         base  <= start_addr;
         len_q <= len;
         beat  <= '0;
      end else if (inc && !last) begin
         beat  <= beat + 1'b1;
      end
   end

   assign addr      = base + ADDR_WIDTH'(beat);
   assign last      = (beat == len_q);
   // One extra bit catches a burst that would run past the top word.
   assign range_err = ({1'b0, start_addr} + (ADDR_WIDTH + 1)'(len)) > ADDR_MAX;

endmodule

// File: rtl/mem_master.sv
// Burst initiator for a single-port word memory. Optional write readback check
// is enabled by defining MEM_MASTER_WRITE_VERIFY_EN.
module mem_master
   import mem_master_pkg::*;
#(
   parameter  int ADDR_WIDTH   = 4,
   parameter  int WORD_WIDTH   = 32,
   parameter  int MAX_BURST    = 4,
   parameter  int READ_LATENCY = 1,
   localparam int LEN_W        = len_width(MAX_BURST)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_W-1:0]      req_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [WORD_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   output logic [WORD_WIDTH-1:0] rd_data,
   output logic                  done,
   output logic                  err,
   mem_master_if.master          mem
);

   localparam int LAT_W = lat_width(READ_LATENCY);

   state_t                state, state_nxt;
   logic                  rst_q;
   logic [LAT_W-1:0]      lat_cnt;
   logic                  lat_last;
   logic [ADDR_WIDTH-1:0] addr_hold;
   logic [WORD_WIDTH-1:0] data_hold;
   logic                  rd_strobe, wr_strobe, rd_capture;
   logic                  load, inc;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic                  last, range_err;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
   logic                  write_q;
`endif

   mem_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_W      (LEN_W)
   ) u_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .inc        (inc),
      .start_addr (req_addr),
      .len        (req_len),
      .addr       (cur_addr),
      .last       (last),
      .range_err  (range_err)
   );

   assign lat_last  = (lat_cnt == LAT_W'(READ_LATENCY - 1));
   assign req_ready = (state == IDLE) && !rst_q;

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt  = state;
      load       = 1'b0;
      inc        = 1'b0;
      rd_strobe  = 1'b0;
      wr_strobe  = 1'b0;
      rd_capture = 1'b0;
      wr_ready   = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               load = 1'b1;
               if (range_err)      state_nxt = ERR;
               else if (req_write) state_nxt = WR_BEAT;
               else                state_nxt = RD_ISSUE;
            end
         end
         RD_ISSUE: begin
            rd_strobe = 1'b1;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
            state_nxt = write_q ? VERIFY : RD_WAIT;
`else
            state_nxt = RD_WAIT;
`endif
         end
         RD_WAIT: begin
            if (lat_last) begin
               rd_capture = 1'b1;
               if (last) begin
                  state_nxt = DONE;
               end else begin
                  inc       = 1'b1;
                  state_nxt = RD_ISSUE;
               end
            end
         end
         WR_BEAT: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               wr_strobe = 1'b1;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
               state_nxt = RD_ISSUE;
`else
               if (last) begin
                  state_nxt = DONE;
               end else begin
                  inc       = 1'b1;
                  state_nxt = WR_BEAT;
               end
`endif
            end
         end
`ifdef MEM_MASTER_WRITE_VERIFY_EN
         VERIFY: begin
            // data_hold still carries the word written by this beat.
            if (lat_last) begin
               if (mem.data_in != data_hold) begin
                  state_nxt = ERR;
               end else if (last) begin
                  state_nxt = DONE;
               end else begin
                  inc       = 1'b1;
                  state_nxt = WR_BEAT;
               end
            end
         end
`endif
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         ERR: begin
            err       = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rst_q     <= 1'b1;
         lat_cnt   <= '0;
         addr_hold <= '0;
         data_hold <= '0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
      end else begin
         state    <= state_nxt;
         rst_q    <= 1'b0;
         rd_valid <= rd_capture;
         if (rd_capture)             rd_data   <= mem.data_in;
         if (rd_strobe || wr_strobe) addr_hold <= cur_addr;
         if (wr_strobe)              data_hold <= wr_data;
         if (state == RD_WAIT || state == VERIFY) lat_cnt <= lat_cnt + 1'b1;
         else                                     lat_cnt <= '0;
      end
   end

`ifdef MEM_MASTER_WRITE_VERIFY_EN
   always_ff @(posedge clk) begin
      if (rst)       write_q <= 1'b0;
      else if (load) write_q <= req_write;
   end
`endif

   // Address and write data hold their last driven values while strobes are low.
   assign mem.memRead  = rd_strobe;
   assign mem.memWrite = wr_strobe;
   assign mem.address  = (rd_strobe || wr_strobe) ? cur_addr : addr_hold;
   assign mem.data_out = wr_strobe ? wr_data : data_hold;

   a_no_rd_wr: assert property (@(posedge clk) disable iff (rst)
      !(mem.memRead && mem.memWrite));

endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Initiator side of the single-port word memory interface (`memRead`/`memWrite`/`address`/data), i.e. the block that drives the memory.
- Accepts read or write burst requests from a core-side valid/ready port and sequences them onto the memory port one word at a time.
- Enforces memory-port legality: never read and write together, never an out-of-range or wrapping address.
- Returns read data, and signals completion or error per burst.

Parameters:
- ADDR_WIDTH, 4, memory address width in words.
- WORD_WIDTH, 32, data word width.
- MAX_BURST, 4, maximum words per burst (power of two, ≥1).
- READ_LATENCY, 1, cycles from `memRead`+`address` asserted to valid memory read data.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  block accepts a request (high only in IDLE).
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_WIDTH  start word address.
- req_len  in  LEN_W  burst length minus one (LEN_W = `$clog2(MAX_BURST)`, min 1).
- wr_valid  in  1  write beat data valid.
- wr_ready  out  1  write beat accepted this cycle.
- wr_data  in  WORD_WIDTH  write beat data.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- rd_data  out  WORD_WIDTH  read beat data.
- done  out  1  one-cycle pulse, burst finished without error.
- err  out  1  one-cycle pulse, burst rejected or aborted.
- memRead  out  1  memory read strobe.
- memWrite  out  1  memory write strobe.
- address  out  ADDR_WIDTH  memory word address.
- data_out  out  WORD_WIDTH  write data to the memory's data_in.
- data_in  in  WORD_WIDTH  read data from memory.

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready (1 one cycle after rst deasserts). Reset mid-burst aborts immediately, with no done or err pulse.
- Request acceptance:
  - On req_valid & req_ready, latch write flag, start address A, len L, beat counter 0.
  - If A + L > 2^ADDR_WIDTH−1 (burst would wrap), go to ERR. No memory strobe is issued.
- States and transitions:
  - IDLE → RD_ISSUE | WR_BEAT | ERR.
  - RD_ISSUE: memRead=1, address=A+beat for exactly one cycle → RD_WAIT.
  - RD_WAIT: count READ_LATENCY cycles from the issue edge. On the last cycle, capture data_in into rd_data and pulse rd_valid. Then: beat==L → DONE, else beat++ → RD_ISSUE. Per read beat = READ_LATENCY+1 cycles; no backpressure on rd_*.
  - WR_BEAT: wr_ready=1.
    - When wr_valid: memWrite=1, address=A+beat, data_out=wr_data in that same cycle (memory writes on that edge).
    - Then: beat==L → DONE, else beat++ and stay. A stalled wr_valid holds memWrite=0.
  - DONE: pulse done for 1 cycle → IDLE.
  - ERR: pulse err for 1 cycle → IDLE.
- Invariant: memRead & memWrite is never 1 in the same cycle (assertion required).
- address/data_out hold last values when strobes are low.
- Back-to-back requests: earliest acceptance is the cycle after the done/err pulse.
- Arithmetic: address sum in ADDR_WIDTH+1 bits for the range check; beat counter LEN_W bits, never wraps.

Optional Feature:
MEM_MASTER_WRITE_VERIFY_EN
- Defined: after each write beat, issue one read of the same address (RD_ISSUE/RD_WAIT timing).
  - Compare with the written word.
  - On mismatch: abort the burst → ERR, with no further beats.
  - Match readback does not pulse rd_valid.
  - Write beat cost becomes READ_LATENCY+2 cycles.
- Undefined: writes are unverified, as above.

Decomposition:
- Package mem_master_pkg: state enum (IDLE, RD_ISSUE, RD_WAIT, WR_BEAT, VERIFY, DONE, ERR); LEN_W/latency-counter width functions.
- Sub-module mem_addr_gen: holds base address and beat counter. Outputs current address, a last-beat flag, and a wrap/range-error flag from (A, L).

Test Plan:
- Write A=3, L=0, wr_data=1 → one memWrite cycle at address 3; done 1 cycle later; then read A=3 → rd_data=1.
- Write burst A=8, L=3, data 0x11..0x44 with wr_valid low for 2 cycles mid-burst → memWrite only on valid cycles, addresses 8..11; read-back burst returns 0x11,0x22,0x33,0x44 with one rd_valid each, READ_LATENCY+1 apart.
- Read A=0xE, L=3 (ADDR_WIDTH=4) → err pulse, no memRead/memWrite ever asserted. Read A=0xC, L=3 → accepted, last address 0xF.
- Assert rst during beat 2 of a 4-beat write → strobes 0 the next cycle, no done/err, req_ready=1 after rst drops.
- Random mix of 200 requests → memRead&memWrite never both 1; done+err count equals accepted requests.
- With MEM_MASTER_WRITE_VERIFY_EN and the memory model forced to corrupt address 5: write A=4, L=2 → beat at 4 ok, err after readback of 5, no write to 6.
